// File: rtl/pixel_ctrl_pkg.sv
// Shared types and helpers for the pixel frame sequencer: FSM state encoding,
// default conversion counter width and the binary-to-Gray encoder.
package pixel_ctrl_pkg;

   localparam int CNT_W_DEF = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PIX_RST,
      S_ERASE,
      S_EXPOSE,
      S_CONVERT,
      S_READOUT,
      S_DONE
   } state_t;

   function automatic logic [31:0] gray_encode(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/pixel_conv_counter.sv
// Single-slope conversion counter with clear/enable. Output is the binary count,
// or its Gray code when GRAY_COUNTER_EN is defined.
module pixel_conv_counter
   import pixel_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             last
);

   logic [CNT_W-1:0] bin_q;
   logic [CNT_W-1:0] bin_n;
   logic [CNT_W-1:0] out_n;

   always_comb begin
      bin_n = bin_q;
      if (clr) begin
         bin_n = '0;
      end else if (en) begin
         bin_n = bin_q + CNT_W'(1);
      end
   end

`ifdef GRAY_COUNTER_EN
   assign out_n = CNT_W'(gray_encode(32'(bin_n)));
`else
   assign out_n = bin_n;
`endif

   // The output is registered from the next binary value so it stays aligned with bin_q.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_q <= '0;
         count <= '0;
      end else begin
         bin_q <= bin_n;
         count <= out_n;
      end
   end

   assign last = &bin_q;

endmodule

// File: rtl/pixel_frame_sequencer.sv
// Frame controller for the pixel array: reset, erase, expose, convert, then row readout.
// Define GRAY_COUNTER_EN to broadcast COUNTER in Gray code instead of binary.
module pixel_frame_sequencer
   import pixel_ctrl_pkg::*;
#(
   parameter int NUM_ROWS     = 2,
   parameter int ERASE_CYCLES = 4,
   parameter int CNT_W        = CNT_W_DEF,
   localparam int ROW_W       = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                START,
   input  logic                ABORT,
   input  logic [7:0]          EXPOSURE,
   input  logic                RD_READY,
   output logic                PIXEL_RST,
   output logic                ERASE,
   output logic                EXPOSE,
   output logic                VBN1,
   output logic                RAMP,
   output logic [CNT_W-1:0]    COUNTER,
   output logic [NUM_ROWS-1:0] READ,
   output logic [ROW_W-1:0]    ROW_ADDR,
   output logic                DATA_VALID,
   output logic                BUSY,
   output logic                FRAME_DONE,
   output logic [2:0]          DEBUG_STATE
);

   localparam int DUR_W = ($clog2(ERASE_CYCLES) > 8) ? $clog2(ERASE_CYCLES) : 8;

   state_t           state_q, state_n;
   logic [DUR_W-1:0] dur_q, dur_n;
   logic [ROW_W-1:0] row_q, row_n;
   logic [7:0]       exp_q, exp_n;
   logic             cnt_clr, cnt_en, cnt_last;

   // Handshake: DATA_VALID is high for the whole READOUT state and never drops while
   // waiting; a row retires on a cycle with DATA_VALID && RD_READY and the next row
   // is presented on the following cycle.
   always_comb begin
      state_n = state_q;
      dur_n   = dur_q;
      row_n   = row_q;
      exp_n   = exp_q;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               state_n = S_PIX_RST;
               exp_n   = EXPOSURE;
               cnt_clr = 1'b1;
            end
         end
         S_PIX_RST: begin
            state_n = S_ERASE;
            dur_n   = DUR_W'(ERASE_CYCLES - 1);
         end
         S_ERASE: begin
            if (dur_q == '0) begin
               state_n = S_EXPOSE;
               dur_n   = (exp_q == 8'd0) ? '0 : DUR_W'(exp_q - 8'd1);
            end else begin
               dur_n = dur_q - DUR_W'(1);
            end
         end
         S_EXPOSE: begin
            if (dur_q == '0) begin
               state_n = S_CONVERT;
            end else begin
               dur_n = dur_q - DUR_W'(1);
            end
         end
         S_CONVERT: begin
            // The counter stops on its final code instead of wrapping.
            if (cnt_last) begin
               state_n = S_READOUT;
               row_n   = '0;
            end else begin
               cnt_en = 1'b1;
            end
         end
         S_READOUT: begin
            if (RD_READY) begin
               if (row_q == ROW_W'(NUM_ROWS - 1)) begin
                  state_n = S_DONE;
                  row_n   = '0;
               end else begin
                  row_n = row_q + ROW_W'(1);
               end
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase
      if (ABORT && (state_q != S_IDLE)) begin
         state_n = S_IDLE;
         dur_n   = '0;
         row_n   = '0;
         cnt_en  = 1'b0;
         cnt_clr = 1'b0;
      end
   end

   // Outputs are decoded from the next state so every line changes on the state edge.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= S_IDLE;
         dur_q      <= '0;
         row_q      <= '0;
         exp_q      <= '0;
         PIXEL_RST  <= 1'b0;
         ERASE      <= 1'b0;
         EXPOSE     <= 1'b0;
         VBN1       <= 1'b0;
         RAMP       <= 1'b0;
         READ       <= '0;
         ROW_ADDR   <= '0;
         DATA_VALID <= 1'b0;
         BUSY       <= 1'b0;
         FRAME_DONE <= 1'b0;
      end else begin
         state_q    <= state_n;
         dur_q      <= dur_n;
         row_q      <= row_n;
         exp_q      <= exp_n;
         PIXEL_RST  <= (state_n == S_PIX_RST);
         ERASE      <= (state_n == S_ERASE);
         EXPOSE     <= (state_n == S_EXPOSE);
         VBN1       <= (state_n == S_CONVERT);
         RAMP       <= (state_n == S_CONVERT);
         READ       <= (state_n == S_READOUT) ? (NUM_ROWS'(1) << row_n) : '0;
         ROW_ADDR   <= (state_n == S_READOUT) ? row_n : '0;
         DATA_VALID <= (state_n == S_READOUT);
         BUSY       <= (state_n != S_IDLE);
         FRAME_DONE <= (state_n == S_DONE);
      end
   end

   pixel_conv_counter #(
      .CNT_W (CNT_W)
   ) u_conv_counter (
      .clk   (CLK),
      .rst   (RESET),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .count (COUNTER),
      .last  (cnt_last)
   );

   assign DEBUG_STATE = state_q;

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Self-checking bench for pixel_frame_sequencer: directed frames plus random
// start/abort/ready traffic compared against a timeline model of the frame.
module tb_pixel_frame_sequencer;

   localparam int NR   = 2;
   localparam int EC   = 4;
   localparam int CW   = 8;
   localparam int CONV = 1 << CW;
`ifdef GRAY_COUNTER_EN
   localparam bit GRAY = 1'b1;
`else
   localparam bit GRAY = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          rd_ready = 1'b0;
   logic [7:0]    exposure = 8'd0;
   logic          pixel_rst, erase, expose, vbn1, ramp, data_valid, busy, frame_done;
   logic [CW-1:0] counter;
   logic [NR-1:0] read;
   logic          row_addr;
   logic [2:0]    debug_state;

   int checks = 0;
   int errors = 0;

   // Model: frame timeline as elapsed cycles since START plus rows transferred.
   int m_active = 0;
   int m_t = 0;
   int m_x = 0;
   int m_rows = 0;
   int m_cnt = 0;
   logic [CW-1:0] prev_counter = '0;

   pixel_frame_sequencer #(.NUM_ROWS(NR), .ERASE_CYCLES(EC), .CNT_W(CW)) dut (
      .CLK(clk), .RESET(rst), .START(start), .ABORT(abort), .EXPOSURE(exposure),
      .RD_READY(rd_ready), .PIXEL_RST(pixel_rst), .ERASE(erase), .EXPOSE(expose),
      .VBN1(vbn1), .RAMP(ramp), .COUNTER(counter), .READ(read), .ROW_ADDR(row_addr),
      .DATA_VALID(data_valid), .BUSY(busy), .FRAME_DONE(frame_done),
      .DEBUG_STATE(debug_state)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // 0 idle, 1 pixel reset, 2 erase, 3 expose, 4 convert, 5 readout, 6 done
   function automatic int m_phase();
      if (m_active == 0) return 0;
      if (m_t == 1) return 1;
      if (m_t <= 1 + EC) return 2;
      if (m_t <= 1 + EC + m_x) return 3;
      if (m_t <= 1 + EC + m_x + CONV) return 4;
      if (m_rows < NR) return 5;
      return 6;
   endfunction

   function automatic logic [CW-1:0] exp_counter(input int c);
      logic [CW-1:0] b;
      b = CW'(c);
      return GRAY ? (b ^ (b >> 1)) : b;
   endfunction

   task automatic m_step();
      int p;
      if (rst) begin
         m_active = 0; m_t = 0; m_rows = 0; m_cnt = 0;
         return;
      end
      p = m_phase();
      if (p == 0) begin
         if (start) begin
            m_active = 1; m_t = 1; m_rows = 0; m_cnt = 0;
            m_x = (exposure == 8'd0) ? 1 : int'(exposure);
         end
      end else if (abort) begin
         m_active = 0;
      end else if (p == 5) begin
         if (rd_ready) m_rows++;
      end else if (p == 6) begin
         m_active = 0;
      end else begin
         m_t++;
      end
      if (m_phase() == 4) m_cnt = m_t - (2 + EC + m_x);
   endtask

   task automatic compare_all();
      int p;
      logic [7:0] e_ctrl;
      int e_step;
      p = m_phase();
      e_ctrl = {p == 1, p == 2, p == 3, p == 4, p == 4, p == 5, p != 0, p == 6};
      check_eq("ctrl", 32'({pixel_rst, erase, expose, vbn1, ramp, data_valid, busy, frame_done}),
               32'(e_ctrl));
      check_eq("read", 32'(read), (p == 5) ? (32'd1 << m_rows) : 32'd0);
      check_eq("row_addr", 32'(row_addr), (p == 5) ? 32'(m_rows) : 32'd0);
      check_eq("counter", 32'(counter), 32'(exp_counter(m_cnt)));
      if (p == 4 && m_cnt > 0) begin
         e_step = GRAY ? 1 : $countones(CW'(m_cnt) ^ CW'(m_cnt - 1));
         check_eq("counter_step", 32'($countones(counter ^ prev_counter)), 32'(e_step));
      end
      prev_counter = counter;
   endtask

   task automatic cycle();
      @(posedge clk);
      m_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic run_frame(input int budget, input bit noisy, output int len, output int exp_cyc);
      start = 1'b1;
      cycle();
      start = 1'b0;
      len = 1;
      exp_cyc = int'(expose);
      while (!frame_done && len < budget) begin
         start = noisy ? ($urandom_range(0, 3) == 0) : 1'b0;
         cycle();
         len++;
         exp_cyc += int'(expose);
      end
      start = 1'b0;
      if (!frame_done) check_eq("frame_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int len, exp_cyc, n;
      @(negedge clk);
      @(negedge clk);
      compare_all();
      rst = 1'b0;
      cycle();

      // Nominal frame
      exposure = 8'd10; rd_ready = 1'b1;
      run_frame(2000, 1'b0, len, exp_cyc);
      check_eq("len_exp10", 32'(len), 32'(1 + EC + 10 + CONV + NR + 1));
      check_eq("expose_10", 32'(exp_cyc), 32'd10);
      cycle();
      check_eq("busy_after_done", 32'(busy), 32'd0);

      // Zero exposure behaves as one cycle
      exposure = 8'd0;
      run_frame(2000, 1'b0, len, exp_cyc);
      check_eq("expose_0", 32'(exp_cyc), 32'd1);
      check_eq("len_exp0", 32'(len), 32'(1 + EC + 1 + CONV + NR + 1));
      repeat (2) cycle();

      // Readout stall on row 0
      exposure = 8'd3; rd_ready = 1'b0;
      start = 1'b1; cycle(); start = 1'b0;
      n = 0;
      while (!data_valid && n < 400) begin cycle(); n++; end
      check_eq("stall_reach_readout", 32'(data_valid), 32'd1);
      repeat (5) begin
         cycle();
         check_eq("stall_read", 32'(read), 32'd1);
         check_eq("stall_valid", 32'(data_valid), 32'd1);
      end
      rd_ready = 1'b1;
      cycle();
      check_eq("row1_read", 32'(read), 32'd2);
      check_eq("row1_addr", 32'(row_addr), 32'd1);
      cycle();
      check_eq("stall_done", 32'(frame_done), 32'd1);
      repeat (2) cycle();

      // Abort at convert cycle 100
      exposure = 8'd5;
      start = 1'b1; cycle(); start = 1'b0;
      n = 0;
      while (!(m_phase() == 4 && m_cnt == 99) && n < 400) begin cycle(); n++; end
      check_eq("abort_reach", 32'(counter), 32'(exp_counter(99)));
      abort = 1'b1; cycle(); abort = 1'b0;
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_cnt", 32'(counter), 32'(exp_counter(99)));
      check_eq("abort_no_done", 32'(frame_done), 32'd0);
      abort = 1'b1; cycle(); abort = 1'b0;
      check_eq("abort_idle", 32'(busy), 32'd0);
      exposure = 8'd7;
      run_frame(2000, 1'b0, len, exp_cyc);
      check_eq("len_after_abort", 32'(len), 32'(1 + EC + 7 + CONV + NR + 1));
      repeat (2) cycle();

      // Reset mid-expose
      exposure = 8'd20;
      start = 1'b1; cycle(); start = 1'b0;
      n = 0;
      while (!expose && n < 50) begin cycle(); n++; end
      repeat (3) cycle();
      check_eq("pre_reset_expose", 32'(expose), 32'd1);
      rst = 1'b1;
      #1;
      check_eq("rst_async_ctrl", 32'({pixel_rst, erase, expose, vbn1, ramp, data_valid, busy, frame_done}), 32'd0);
      check_eq("rst_async_cnt", 32'(counter), 32'd0);
      cycle();
      rst = 1'b0;
      cycle();
      exposure = 8'd9;
      run_frame(2000, 1'b1, len, exp_cyc);
      check_eq("len_start_noise", 32'(len), 32'(1 + EC + 9 + CONV + NR + 1));
      cycle();

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         start    = ($urandom_range(0, 9) == 0);
         abort    = ($urandom_range(0, 199) == 0);
         rd_ready = ($urandom_range(0, 2) != 0);
         exposure = 8'($urandom_range(0, 12));
         cycle();
      end
      start = 1'b0; abort = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
